btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/clock_pkg.sv | 34 +++
 rtl/btn_channel.sv | 198 +++++++++++++++++++
 rtl/btn_conditioner.sv | 45 ++++
 3 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Brief    : Shared encodings for the clock front panel (modes, button FSM).
// Revision : 1.0
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_ALARM    = 2'd3
    } clock_mode_t;

    typedef enum logic [2:0] {
        BTN_IDLE     = 3'd0,
        BTN_DB_PRESS = 3'd1,
        BTN_PRESSED  = 3'd2,
        BTN_HELD     = 3'd3,
        BTN_DB_REL   = 3'd4
    } btn_state_t;

    // One counter width serves debounce, hold and repeat timing.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module   : btn_channel
// Brief    : One button: 2-flop synchronizer, debounce/long-press FSM, timers.
// Revision : 1.0
// ============================================================================
module btn_channel
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
)(
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_db,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
    // The sample that moves IDLE->DB_PRESS counts as the first stable one.
    localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic r_sync1;
    logic r_sync2;

    btn_state_t       r_state;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_from_held;
    logic             r_btn_db;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_repeat;

    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic             w_from_held_nxt;
    logic             w_btn_db_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_long_nxt;
    logic             w_repeat_nxt;
    logic             w_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= BTN_IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_rpt_cnt   <= '0;
            r_from_held <= 1'b0;
            r_btn_db    <= 1'b1;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_from_held <= w_from_held_nxt;
            r_btn_db    <= w_btn_db_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
            r_repeat    <= w_repeat_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_db_cnt_nxt    = r_db_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_from_held_nxt = r_from_held;
        w_btn_db_nxt    = r_btn_db;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_repeat_nxt    = 1'b0;

        case (r_state)
            BTN_IDLE: begin
                w_btn_db_nxt = 1'b1;
                if (!w_s) begin
                    w_state_nxt  = BTN_DB_PRESS;
                    w_db_cnt_nxt = '0;
                end
            end

            BTN_DB_PRESS: begin
                w_btn_db_nxt = 1'b1;
                if (w_s) begin
                    w_state_nxt = BTN_IDLE;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt     = BTN_PRESSED;
                    w_btn_db_nxt    = 1'b0;
                    w_press_nxt     = 1'b1;
                    w_hold_cnt_nxt  = '0;
                    w_rpt_cnt_nxt   = '0;
                    w_from_held_nxt = 1'b0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_ONE;
                end
            end

            // A release candidate still ticks the timer but never fires an
            // event; a terminal count waits for the bounce to resolve.
            BTN_PRESSED: begin
                w_btn_db_nxt = 1'b0;
                if (w_s) begin
                    w_state_nxt     = BTN_DB_REL;
                    w_db_cnt_nxt    = '0;
                    w_from_held_nxt = 1'b0;
                    if (r_hold_cnt != c_LONG_LAST)
                        w_hold_cnt_nxt = r_hold_cnt + c_ONE;
                end else if (r_hold_cnt == c_LONG_LAST) begin
                    w_state_nxt   = BTN_HELD;
                    w_long_nxt    = 1'b1;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + c_ONE;
                end
            end

            BTN_HELD: begin
                w_btn_db_nxt = 1'b0;
                if (w_s) begin
                    w_state_nxt     = BTN_DB_REL;
                    w_db_cnt_nxt    = '0;
                    w_from_held_nxt = 1'b1;
                    if (r_rpt_cnt != c_RPT_LAST)
                        w_rpt_cnt_nxt = r_rpt_cnt + c_ONE;
                end else if (r_rpt_cnt == c_RPT_LAST) begin
                    w_repeat_nxt  = 1'b1;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + c_ONE;
                end
            end

            BTN_DB_REL: begin
                w_btn_db_nxt = 1'b0;
                if (!w_s) begin
                    w_state_nxt = r_from_held ? BTN_HELD : BTN_PRESSED;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt   = BTN_IDLE;
                    w_btn_db_nxt  = 1'b1;
                    w_release_nxt = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_ONE;
                end
            end

            default: begin
                w_state_nxt     = BTN_IDLE;
                w_btn_db_nxt    = 1'b1;
                w_db_cnt_nxt    = '0;
                w_hold_cnt_nxt  = '0;
                w_rpt_cnt_nxt   = '0;
                w_from_held_nxt = 1'b0;
            end
        endcase
    end

    assign btn_db        = r_btn_db;
    assign press         = r_press;
    assign release_pulse = r_release;
    assign long_press    = r_long;
    assign repeat_pulse  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : N independent button channels: debounced level plus event pulses.
// Revision : 1.0
// ============================================================================
module btn_conditioner
    import clock_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_pulse
);

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_ch
            btn_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES)
            ) u_ch (
                .clk           (clk),
                .reset         (reset),
                .btn_n         (btn_n[i]),
                .btn_db        (btn_db[i]),
                .press         (press[i]),
                .release_pulse (release_pulse[i]),
                .long_press    (long_press[i]),
                .repeat_pulse  (repeat_pulse[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
